// File: rtl/screen_pkg.sv
// Shared types and defaults for the screen sequencer. Build with PAUSE_EN
// defined to add the PAUSED state.
package screen_pkg;

  localparam int RGB_W            = 12;
  localparam int SHOOT_FRAMES_DEF = 120;
  localparam int OVER_FRAMES_DEF  = 180;
  localparam int MAX_ROUNDS_DEF   = 3;
  localparam int V_ACTIVE_DEF     = 480;

`ifdef PAUSE_EN
  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    SHOOT  = 3'd1,
    PLAY   = 3'd2,
    OVER   = 3'd3,
    PAUSED = 3'd4
  } state_e;

  // PAUSED shows as PLAY on the 2-bit screen code.
  function automatic logic [1:0] screen_code(input state_e s);
    logic [2:0] v;
    v = s;
    return (s == PAUSED) ? 2'd2 : v[1:0];
  endfunction
`else
  typedef enum logic [1:0] {
    TITLE = 2'd0,
    SHOOT = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  function automatic logic [1:0] screen_code(input state_e s);
    return s;
  endfunction
`endif

endpackage

// File: rtl/screen_sequencer_if.sv
// Video timing, button, renderer and VGA signals of the screen sequencer.
// The sequencer takes the slave side; the driving environment takes master.
interface screen_sequencer_if;
  import screen_pkg::*;

  logic [9:0]       Hcount;
  logic [9:0]       Vcount;
  logic             video_on;
  logic             start_btn;
  logic             pause_btn;
  logic             round_done;
  logic [RGB_W-1:0] title_rgb;
  logic [RGB_W-1:0] shoot_rgb;
  logic [RGB_W-1:0] game_rgb;
  logic [RGB_W-1:0] over_rgb;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;
  logic             game_en;
  logic [3:0]       round_cnt;
  logic [1:0]       screen;

  // No valid/ready here: inputs are level/pulse signals sampled every clock,
  // outputs are registered and valid every clock after reset.
  modport slave (
    input  Hcount, Vcount, video_on, start_btn, pause_btn, round_done,
    input  title_rgb, shoot_rgb, game_rgb, over_rgb,
    output red, green, blue, game_en, round_cnt, screen
  );

  modport master (
    output Hcount, Vcount, video_on, start_btn, pause_btn, round_done,
    output title_rgb, shoot_rgb, game_rgb, over_rgb,
    input  red, green, blue, game_en, round_cnt, screen
  );
endinterface

// File: rtl/screen_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a
// one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/screen_sequencer.sv
// Game-flow screen sequencer: TITLE/SHOOT/PLAY/OVER, frame-aligned changes,
// registered RGB mux. PAUSE_EN adds a PAUSED state driven by pause_btn.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int SHOOT_FRAMES = SHOOT_FRAMES_DEF,
  parameter int OVER_FRAMES  = OVER_FRAMES_DEF,
  parameter int MAX_ROUNDS   = MAX_ROUNDS_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  screen_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [3:0]       round_cnt_q, round_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             game_en_q, game_en_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             start_pend_q, start_pend_d;
  logic             round_pend_q, round_pend_d;
  logic             start_rise;
  logic             frame_tick;
  logic             hold_cnt;
  logic             round_clr;

  assign frame_tick = (bus.Hcount == 10'd0) && (bus.Vcount == 10'(V_ACTIVE));

  btn_sync_edge u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.start_btn),
    .rise  (start_rise)
  );

`ifdef PAUSE_EN
  logic pause_rise;
  logic pause_pend_q, pause_pend_d;

  btn_sync_edge u_pause_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.pause_btn),
    .rise  (pause_rise)
  );
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
`endif

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt    = 1'b0;
    // Every tick either consumes or discards start_pend; round_pend survives
    // a tick only while paused. A fresh edge in the clearing cycle still sets.
    round_clr    = frame_tick;
`ifdef PAUSE_EN
    round_clr    = frame_tick && (state_q != PAUSED);
    pause_pend_d = pause_rise | (pause_pend_q & ~frame_tick);
`endif
    start_pend_d = start_rise | (start_pend_q & ~frame_tick);
    round_pend_d = bus.round_done | (round_pend_q & ~round_clr);

    if (frame_tick) begin
      case (state_q)
        TITLE: if (start_pend_q) begin
          state_d     = SHOOT;
          round_cnt_d = 4'd0;
        end
        SHOOT: if (frame_cnt_q == 8'(SHOOT_FRAMES - 1)) state_d = PLAY;
        PLAY: begin
          if (round_pend_q) begin
            if (round_cnt_q < 4'(MAX_ROUNDS - 1)) begin
              round_cnt_d = round_cnt_q + 4'd1;
              state_d     = SHOOT;
            end else begin
              state_d = OVER;
            end
          end
`ifdef PAUSE_EN
          else if (pause_pend_q) state_d = PAUSED;
`endif
        end
        OVER: if (start_pend_q || (frame_cnt_q == 8'(OVER_FRAMES - 1))) state_d = TITLE;
`ifdef PAUSE_EN
        PAUSED: if (pause_pend_q) state_d = PLAY;
`endif
        default: state_d = TITLE;
      endcase

`ifdef PAUSE_EN
      hold_cnt = (state_q == PAUSED) || (state_d == PAUSED);
`endif
      if (hold_cnt)                 frame_cnt_d = frame_cnt_q;
      else if (state_d != state_q)  frame_cnt_d = 8'd0;
      else if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    game_en_d = (state_d == PLAY);

    case (state_q)
      TITLE:   rgb_d = bus.title_rgb;
      SHOOT:   rgb_d = bus.shoot_rgb;
      PLAY:    rgb_d = bus.game_rgb;
      OVER:    rgb_d = bus.over_rgb;
`ifdef PAUSE_EN
      PAUSED:  rgb_d = {1'b0, bus.game_rgb[11:9], 1'b0, bus.game_rgb[7:5],
                        1'b0, bus.game_rgb[3:1]};
`endif
      default: rgb_d = '0;
    endcase
    if (!bus.video_on) rgb_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TITLE;
      round_cnt_q  <= 4'd0;
      frame_cnt_q  <= 8'd0;
      game_en_q    <= 1'b0;
      rgb_q        <= '0;
      start_pend_q <= 1'b0;
      round_pend_q <= 1'b0;
`ifdef PAUSE_EN
      pause_pend_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      round_cnt_q  <= round_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      game_en_q    <= game_en_d;
      rgb_q        <= rgb_d;
      start_pend_q <= start_pend_d;
      round_pend_q <= round_pend_d;
`ifdef PAUSE_EN
      pause_pend_q <= pause_pend_d;
`endif
    end
  end

  assign bus.red       = rgb_q[11:8];
  assign bus.green     = rgb_q[7:4];
  assign bus.blue      = rgb_q[3:0];
  assign bus.game_en   = game_en_q;
  assign bus.round_cnt = round_cnt_q;
  assign bus.screen    = screen_code(state_q);
endmodule
